// File: rtl/lif_spike_emitter.sv
// rtl/lif_spike_emitter.sv - LIF fire stage: scans the membrane bank, applies refractory and threshold, emits spikes
module lif_spike_emitter #(
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int VMEM_W     = 16,
    parameter int REF_W      = 4,
    parameter int RESET_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [VMEM_W-1:0] threshold,
    input  logic [REF_W-1:0]  ref_period,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [VMEM_W-1:0] rd_data,
    output logic              corr_valid,
    output logic [IDX_W-1:0]  corr_idx,
    output logic [VMEM_W-1:0] corr_data,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [IDX_W-1:0]  spk_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [VMEM_W-1:0]  thr;
    logic [REF_W-1:0]   ref_len;
    logic [REF_W-1:0]   refr [N_NEURONS];

    logic [REF_W-1:0]   refr_cur;
    logic               in_cmp;
    logic               fire;
    logic               last;
    logic [IDX_W-1:0]   idx_next;

    assign refr_cur = refr[idx];
    assign in_cmp   = (state == S_CMP);
    // thr==0 disables firing, but the refractory branch above it still runs
    assign fire     = in_cmp && (refr_cur == '0) && (thr != '0) && (rd_data >= thr);
    assign last     = (idx == IDX_W'(N_NEURONS - 1));
    assign idx_next = idx + IDX_W'(1);

    // rd_data is only valid during CMP, so the correction is decoded from it directly
    assign corr_valid = in_cmp;
    assign corr_idx   = in_cmp ? idx : '0;
    assign corr_data  = fire ? ((RESET_MODE != 0) ? rd_data : thr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            thr       <= '0;
            ref_len   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            spk_valid <= 1'b0;
            spk_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) refr[i] <= '0;
        end else if (clear) begin
            state     <= S_IDLE;
            idx       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            spk_valid <= 1'b0;
            spk_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) refr[i] <= '0;
        end else begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        thr     <= threshold;
                        ref_len <= ref_period;
                        idx     <= '0;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (refr_cur != '0) begin
                        refr[idx] <= refr_cur - REF_W'(1);
                    end else if (fire) begin
                        refr[idx] <= ref_len;
                    end
                    if (fire) begin
                        spk_valid <= 1'b1;
                        spk_idx   <= idx;
                        state     <= S_EMIT;
                    end else if (last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx     <= idx_next;
                        rd_en   <= 1'b1;
                        rd_addr <= idx_next;
                        state   <= S_READ;
                    end
                end
                S_EMIT: begin
                    if (spk_ready) begin
                        spk_valid <= 1'b0;
                        spk_idx   <= '0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx     <= idx_next;
                            rd_en   <= 1'b1;
                            rd_addr <= idx_next;
                            state   <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_spike_emitter.sv
// tb/tb_lif_spike_emitter.sv - directed bench for lif_spike_emitter with N=4 in both correction modes
module tb_lif_spike_emitter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int VW = 16;
    localparam int RW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clear, start, start2, spk_ready;
    logic [VW-1:0] threshold;
    logic [RW-1:0] ref_period;

    logic          rd_en, corr_valid, spk_valid, busy, done;
    logic [IW-1:0] rd_addr, corr_idx, spk_idx;
    logic [VW-1:0] rd_data, corr_data;

    logic          rd_en2, corr_valid2, spk_valid2, busy2, done2;
    logic [IW-1:0] rd_addr2, corr_idx2, spk_idx2;
    logic [VW-1:0] rd_data2, corr_data2;

    logic [VW-1:0] vmem  [N];
    logic [VW-1:0] vmem2 [N];

    lif_spike_emitter #(.N_NEURONS(N), .IDX_W(IW), .VMEM_W(VW), .REF_W(RW), .RESET_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .threshold(threshold), .ref_period(ref_period),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .corr_valid(corr_valid), .corr_idx(corr_idx), .corr_data(corr_data),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
        .busy(busy), .done(done)
    );

    lif_spike_emitter #(.N_NEURONS(N), .IDX_W(IW), .VMEM_W(VW), .REF_W(RW), .RESET_MODE(1)) dut_rz (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start2),
        .threshold(threshold), .ref_period(ref_period),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .corr_valid(corr_valid2), .corr_idx(corr_idx2), .corr_data(corr_data2),
        .spk_valid(spk_valid2), .spk_ready(spk_ready), .spk_idx(spk_idx2),
        .busy(busy2), .done(done2)
    );

    always_ff @(posedge clk) begin
        if (rd_en)  rd_data  <= vmem[rd_addr];
        if (rd_en2) rd_data2 <= vmem2[rd_addr2];
    end

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [VW-1:0] corr_log [N];
    int spk_q[$];
    int done_cyc, rd_cnt, first_rd, stall_bad, stall_rd, resume_rd;

    // Cycle 1 is the first cycle after the edge that samples start
    task automatic run_scan(input int stall, input int restart_at);
        int cyc;
        int stall_left;
        logic [IW-1:0] held;
        logic stalled, resume_next;
        for (int i = 0; i < N; i++) corr_log[i] = '1;
        spk_q.delete();
        done_cyc = -1; rd_cnt = 0; first_rd = -1;
        stall_bad = 0; stall_rd = 0; resume_rd = -1;
        stall_left = stall; stalled = 1'b0; resume_next = 1'b0; held = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            start = (cyc == restart_at);
            if (resume_next) begin
                resume_rd = int'(rd_en);
                resume_next = 1'b0;
            end
            if (rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (corr_valid) corr_log[corr_idx] = corr_data;
            if (spk_valid) begin
                if (stall_left > 0) begin
                    spk_ready = 1'b0;
                    if (!stalled) held = spk_idx;
                    stalled = 1'b1;
                    stall_left--;
                end else begin
                    spk_ready = 1'b1;
                end
                if (stalled) begin
                    if (spk_idx !== held) stall_bad++;
                    if (rd_en) stall_rd++;
                end
                if (spk_ready) begin
                    spk_q.push_back(int'(spk_idx));
                    if (stalled) resume_next = 1'b1;
                    stalled = 1'b0;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        spk_ready = 1'b1;
        if (done_cyc < 0) check("scan_timeout", 0, 1);
    endtask

    initial begin
        int n, d, c2, spk2, idx2, cidx, cdat, nz;
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; start2 = 1'b0;
        threshold = '0; ref_period = '0; spk_ready = 1'b1;
        vmem  = '{16'd0, 16'd0, 16'd0, 16'd0};
        vmem2 = '{16'd0, 16'd0, 16'd0, 16'd0};
        repeat (2) @(negedge clk);
        check("reset_outs", {rd_en, corr_valid, spk_valid, busy, done, rd_addr, spk_idx}, 0);
        rst_n = 1'b1;

        // basic scan, subtract mode
        vmem = '{16'd50, 16'd100, 16'd99, 16'd200};
        threshold = 16'd100; ref_period = 4'd0;
        run_scan(0, -1);
        check("t1_done_cyc", done_cyc, 11);
        check("t1_first_rd", first_rd, 1);
        check("t1_rd_cnt", rd_cnt, 4);
        check("t1_corr0", corr_log[0], 0);
        check("t1_corr1", corr_log[1], 100);
        check("t1_corr2", corr_log[2], 0);
        check("t1_corr3", corr_log[3], 100);
        check("t1_nspk", spk_q.size(), 2);
        if (spk_q.size() == 2) begin
            check("t1_spk_a", spk_q[0], 1);
            check("t1_spk_b", spk_q[1], 3);
        end
        @(negedge clk);
        check("t1_done_pulse", {done, busy}, 0);

        // reset-to-zero mode on the second instance
        vmem2 = '{16'd0, 16'd0, 16'd300, 16'd0};
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        c2 = 0; spk2 = 0; idx2 = -1; cidx = -1; cdat = 0; nz = 0;
        while (!done2 && c2 < 60) begin
            if (corr_valid2 && corr_data2 != '0) begin
                nz++; cidx = int'(corr_idx2); cdat = int'(corr_data2);
            end
            if (spk_valid2 && spk_ready) begin
                spk2++; idx2 = int'(spk_idx2);
            end
            @(negedge clk);
            c2++;
        end
        check("t2_done", done2, 1);
        check("t2_corr_nz", nz, 1);
        check("t2_corr_idx", cidx, 2);
        check("t2_corr_data", cdat, 300);
        check("t2_nspk", spk2, 1);
        check("t2_spk_idx", idx2, 2);

        // backpressure on neuron 1
        vmem = '{16'd0, 16'd150, 16'd0, 16'd0};
        run_scan(5, -1);
        check("t4_done_cyc", done_cyc, 15);
        check("t4_idx_stable", stall_bad, 0);
        check("t4_no_rd_stall", stall_rd, 0);
        check("t4_resume_rd", resume_rd, 1);
        check("t4_nspk", spk_q.size(), 1);

        // refractory period of 2 across four timesteps
        vmem = '{16'd500, 16'd0, 16'd0, 16'd0};
        ref_period = 4'd2;
        run_scan(0, -1); check("t3_ts0", spk_q.size(), 1);
        run_scan(0, -1); check("t3_ts1", spk_q.size(), 0);
        run_scan(0, -1); check("t3_ts2", spk_q.size(), 0);
        run_scan(0, -1); check("t3_ts3", spk_q.size(), 1);
        check("t3_ts3_corr0", corr_log[0], 100);

        // clear while a spike is pending
        vmem = '{16'd0, 16'd0, 16'd300, 16'd0};
        ref_period = 4'd3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; spk_ready = 1'b0;
        n = 0;
        while (!spk_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_emit", spk_valid, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; spk_ready = 1'b1;
        check("t5_after_clear", {busy, spk_valid, rd_en, corr_valid, done, spk_idx}, 0);
        d = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) d++;
        end
        check("t5_no_done", d, 0);
        check("t5_idle", busy, 0);
        // neurons 0 and 2 were refractory before the clear
        vmem = '{16'd500, 16'd0, 16'd300, 16'd0};
        ref_period = 4'd0;
        run_scan(0, -1);
        check("t5_nspk", spk_q.size(), 2);
        if (spk_q.size() == 2) begin
            check("t5_spk_a", spk_q[0], 0);
            check("t5_spk_b", spk_q[1], 2);
        end

        // threshold 0 disables firing; a start mid-scan is ignored
        vmem = '{16'd500, 16'd500, 16'd500, 16'd500};
        threshold = 16'd0;
        run_scan(0, 4);
        check("t6_done_cyc", done_cyc, 9);
        check("t6_nspk", spk_q.size(), 0);
        check("t6_corr1", corr_log[1], 0);
        repeat (3) @(negedge clk);
        check("t6_idle_after", {busy, done, rd_en}, 0);

        // asynchronous reset mid-scan
        vmem = '{16'd0, 16'd500, 16'd0, 16'd0};
        threshold = 16'd100; spk_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!spk_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_emit", spk_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_rst", {rd_en, rd_addr, corr_valid, corr_idx, corr_data, spk_valid, spk_idx, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1; spk_ready = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
